// File: rtl/set_readback_if.sv
// Bus bundle between the CPU bus-cycle logic and the settings readback responder.
// The master side drives the bus cycle and the live settings. The slave side returns data and acknowledge.
interface set_readback_if;
    logic        BACT;
    logic        SetCSRD;
    logic [3:0]  SlowTimeout;
    logic        SlowIACK;
    logic        SlowVIA;
    logic        SlowIWM;
    logic        SlowSCC;
    logic        SlowSCSI;
    logic        SlowSnd;
    logic        SlowClockGate;
    logic        TimeoutEvt;
    logic [15:0] D;
    logic        DOE;
    logic        RdAck;

    modport slave (
        input  BACT, SetCSRD, SlowTimeout, SlowIACK, SlowVIA, SlowIWM, SlowSCC,
               SlowSCSI, SlowSnd, SlowClockGate, TimeoutEvt,
        output D, DOE, RdAck
    );

    modport master (
        output BACT, SetCSRD, SlowTimeout, SlowIACK, SlowVIA, SlowIWM, SlowSCC,
               SlowSCSI, SlowSnd, SlowClockGate, TimeoutEvt,
        input  D, DOE, RdAck
    );
endinterface

// File: rtl/set_readback.sv
// Settings-register read responder: snapshots the slow-mode settings plus a read-to-clear timeout counter.
// Define SET_READBACK_PARITY_EN to place odd parity over D[15:1] in D[0]. Otherwise D[0] is always 0.
module set_readback #(
    parameter int unsigned ACK_DLY = 2
) (
    input logic           CLK,
    input logic           POR,
    set_readback_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] ACK_DLY_C = 3'(ACK_DLY);

`ifdef SET_READBACK_PARITY_EN
    function automatic logic odd_parity(input logic [14:0] v);
        return ~(^v);
    endfunction
`endif

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  evt_q, evt_d;
    logic        setrd_q;
    logic [15:0] d_q, d_d;
    logic        doe_q, doe_d;
    logic        rdack_q, rdack_d;
    logic [3:0]  evt_inc_s;
    logic [15:0] snap_s;

    // Saturating event increment and the data word presented at the snapshot edge.
    always_comb begin
        evt_inc_s = (evt_q == 4'd15) ? 4'd15 : (evt_q + 4'd1);
        snap_s    = {evt_q, bus.SlowTimeout, bus.SlowIACK, bus.SlowVIA, bus.SlowIWM,
                     bus.SlowSCC, bus.SlowSCSI, bus.SlowSnd, bus.SlowClockGate, 1'b0};
`ifdef SET_READBACK_PARITY_EN
        snap_s[0] = odd_parity(snap_s[15:1]);
`endif
    end

    // Next-state and output logic for the read handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        doe_d   = doe_q;
        rdack_d = rdack_q;
        evt_d   = bus.TimeoutEvt ? evt_inc_s : evt_q;
        case (state_q)
            IDLE: begin
                if (setrd_q && bus.BACT) begin
                    d_d     = snap_s;
                    doe_d   = 1'b1;
                    cnt_d   = ACK_DLY_C;
                    state_d = DRIVE;
                    // An event on the snapshot edge is kept for the next read.
                    evt_d   = bus.TimeoutEvt ? 4'd1 : 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (!bus.BACT) begin
                    doe_d   = 1'b0;
                    rdack_d = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    rdack_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                if (!bus.BACT) begin
                    doe_d   = 1'b0;
                    rdack_d = 1'b0;
                    d_d     = 16'h0000;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                doe_d   = 1'b0;
                rdack_d = 1'b0;
                d_d     = 16'h0000;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            evt_q   <= 4'd0;
            setrd_q <= 1'b0;
            d_q     <= 16'h0000;
            doe_q   <= 1'b0;
            rdack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            setrd_q <= bus.BACT && bus.SetCSRD;
            d_q     <= d_d;
            doe_q   <= doe_d;
            rdack_q <= rdack_d;
        end
    end

    assign bus.D     = d_q;
    assign bus.DOE   = doe_q;
    assign bus.RdAck = rdack_q;

endmodule
